// File: rtl/sample_fifo_mc_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sample_fifo_mc_if
// Brief    : Write, pop/ack, read-data and threshold-load bundle of the
//            multi-channel sample read buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface sample_fifo_mc_if #(
  parameter int WIDTH     = 16,
  parameter int DEPTH_BIT = 13,
  parameter int NUM_CH    = 4,
  parameter int CH_BIT    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) ();
  logic                 i_wr_en;
  logic [DEPTH_BIT-1:0] i_wr_addr;
  logic [WIDTH-1:0]     i_wr_data;
  logic [NUM_CH-1:0]    i_pop;
  logic [NUM_CH-1:0]    o_pop_ack;
  logic [WIDTH-1:0]     o_front;
  logic [CH_BIT-1:0]    o_ch;
  logic                 o_vld;
  logic [NUM_CH-1:0]    o_empty;
  logic [NUM_CH-1:0]    i_ptr_rst;
  logic [DEPTH_BIT-1:0] i_thsh_val;
  logic [CH_BIT-1:0]    i_thsh_ch;
  logic                 i_thsh_mode;
  logic                 i_thsh_vld;
  logic                 o_thsh_done;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_pop, i_ptr_rst,
           i_thsh_val, i_thsh_ch, i_thsh_mode, i_thsh_vld,
    input  o_pop_ack, o_front, o_ch, o_vld, o_empty, o_thsh_done
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_pop, i_ptr_rst,
           i_thsh_val, i_thsh_ch, i_thsh_mode, i_thsh_vld,
    output o_pop_ack, o_front, o_ch, o_vld, o_empty, o_thsh_done
  );
endinterface
`default_nettype wire

// File: rtl/sample_fifo_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sample_fifo_mc
// Brief    : Shared sample memory with NUM_CH round-robin arbitrated read
//            channels, each with its own pointer, threshold and replay mode.
// Revision : 1.0 - initial release
// ============================================================================
module sample_fifo_mc #(
  parameter int WIDTH     = 16,
  parameter int DEPTH_BIT = 13,
  parameter int NUM_CH    = 4,
  parameter int CH_BIT    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int OUT_REGS  = 1
) (
  input  logic               clk,
  input  logic               rst,
  sample_fifo_mc_if.slave    bus
);
  localparam int MEM_WORDS = 2 ** DEPTH_BIT;

  logic [WIDTH-1:0]     mem_q [MEM_WORDS];

  logic [DEPTH_BIT-1:0] rptr_q [NUM_CH];
  logic [DEPTH_BIT-1:0] rptr_d [NUM_CH];
  logic [DEPTH_BIT-1:0] thsh_q [NUM_CH];
  logic [DEPTH_BIT-1:0] thsh_d [NUM_CH];
  logic [NUM_CH-1:0]    mode_q, mode_d;
  logic [NUM_CH-1:0]    loaded_q, loaded_d;
  logic [NUM_CH-1:0]    empty_q, empty_d;
  logic [CH_BIT-1:0]    prio_q, prio_d;
  logic                 done_q;

  logic [NUM_CH-1:0]    elig;
  logic [NUM_CH-1:0]    ack;
  logic                 gnt_vld;
  logic [CH_BIT-1:0]    gnt_ch;
  logic [DEPTH_BIT-1:0] rd_addr;

  // Stage 0 is the memory read register; stages 1..OUT_REGS are extra delay.
  logic [WIDTH-1:0]     pdata_q [OUT_REGS+1];
  logic [CH_BIT-1:0]    pch_q   [OUT_REGS+1];
  logic [OUT_REGS:0]    pvld_q;

  always_comb begin
    int idx;
    idx     = 0;
    ack     = '0;
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    rd_addr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      elig[c] = bus.i_pop[c] & ~empty_q[c] & ~bus.i_ptr_rst[c] &
                ~(bus.i_thsh_vld && (bus.i_thsh_ch == CH_BIT'(c)));
    end
    // Scan starting at the channel after the last grant, wrapping around.
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(prio_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      for (int c = 0; c < NUM_CH; c++) begin
        if (!gnt_vld && (c == idx) && elig[c]) begin
          gnt_vld = 1'b1;
          gnt_ch  = CH_BIT'(c);
          ack[c]  = 1'b1;
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (ack[c]) rd_addr = rptr_q[c];
    end
  end

  always_comb begin
    prio_d   = prio_q;
    mode_d   = mode_q;
    loaded_d = loaded_q;
    empty_d  = empty_q;
    if (gnt_vld) begin
      prio_d = (gnt_ch == CH_BIT'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      rptr_d[c] = rptr_q[c];
      thsh_d[c] = thsh_q[c];
      // Threshold load beats pointer clear, which beats a pop.
      if (bus.i_thsh_vld && (bus.i_thsh_ch == CH_BIT'(c))) begin
        thsh_d[c]   = bus.i_thsh_val;
        mode_d[c]   = bus.i_thsh_mode;
        rptr_d[c]   = '0;
        empty_d[c]  = 1'b0;
        loaded_d[c] = 1'b1;
      end else if (bus.i_ptr_rst[c]) begin
        rptr_d[c]  = '0;
        empty_d[c] = ~loaded_q[c];
      end else if (ack[c]) begin
        if (rptr_q[c] == thsh_q[c]) begin
          if (mode_q[c]) rptr_d[c] = '0;
          else           empty_d[c] = 1'b1;
        end else begin
          rptr_d[c] = rptr_q[c] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rptr_q[c] <= '0;
        thsh_q[c] <= '0;
      end
      mode_q   <= '0;
      loaded_q <= '0;
      empty_q  <= '1;
      prio_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        rptr_q[c] <= rptr_d[c];
        thsh_q[c] <= thsh_d[c];
      end
      mode_q   <= mode_d;
      loaded_q <= loaded_d;
      empty_q  <= empty_d;
      prio_q   <= prio_d;
      done_q   <= bus.i_thsh_vld;
    end
  end

  // Read-first: a same-cycle write to rd_addr is not visible to this read.
  always_ff @(posedge clk) begin
    if (bus.i_wr_en) mem_q[bus.i_wr_addr] <= bus.i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pvld_q <= '0;
      for (int k = 0; k <= OUT_REGS; k++) begin
        pdata_q[k] <= '0;
        pch_q[k]   <= '0;
      end
    end else begin
      pvld_q[0] <= gnt_vld;
      if (gnt_vld) begin
        pdata_q[0] <= mem_q[rd_addr];
        pch_q[0]   <= gnt_ch;
      end
      for (int k = 1; k <= OUT_REGS; k++) begin
        pvld_q[k]  <= pvld_q[k-1];
        pdata_q[k] <= pdata_q[k-1];
        pch_q[k]   <= pch_q[k-1];
      end
    end
  end

  assign bus.o_pop_ack   = ack;
  assign bus.o_front     = pdata_q[OUT_REGS];
  assign bus.o_ch        = pch_q[OUT_REGS];
  assign bus.o_vld       = pvld_q[OUT_REGS];
  assign bus.o_empty     = empty_q;
  assign bus.o_thsh_done = done_q;
endmodule
`default_nettype wire

// File: tb/tb_sample_fifo_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sample_fifo_mc
// Brief    : Directed bench for sample_fifo_mc (4 channels, read latency 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_fifo_mc;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  sample_fifo_mc_if #(.WIDTH(16), .DEPTH_BIT(13), .NUM_CH(4), .CH_BIT(2)) bus ();

  sample_fifo_mc #(
    .WIDTH(16), .DEPTH_BIT(13), .NUM_CH(4), .CH_BIT(2), .OUT_REGS(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pop;
    logic [3:0]  prst;
    logic        tv;
    logic [12:0] tval;
    logic        we;
    logic [12:0] wa;
    logic [15:0] wd;
    logic [3:0]  ack;
    logic        vld;
    logic [15:0] front;
    logic [3:0]  empty;
    logic        done;
  } vec_t;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [1:0]  ch;
  } ex_t;

  vec_t tbl [17];
  ex_t  e0, e1;
  logic prev_tv;
  logic prev_rst;

  function automatic vec_t v(input logic [3:0] pop, input logic [3:0] prst,
                             input logic tv, input logic [12:0] tval,
                             input logic we, input logic [12:0] wa,
                             input logic [15:0] wd, input logic [3:0] ack,
                             input logic vld, input logic [15:0] front,
                             input logic [3:0] empty, input logic done);
    vec_t r;
    r.pop = pop;  r.prst = prst; r.tv = tv;   r.tval = tval;
    r.we = we;    r.wa = wa;     r.wd = wd;   r.ack = ack;
    r.vld = vld;  r.front = front; r.empty = empty; r.done = done;
    return r;
  endfunction

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    rst             = 1'b0;
    bus.i_wr_en     = 1'b0;
    bus.i_wr_addr   = 13'd0;
    bus.i_wr_data   = 16'd0;
    bus.i_pop       = 4'h0;
    bus.i_ptr_rst   = 4'h0;
    bus.i_thsh_val  = 13'd0;
    bus.i_thsh_ch   = 2'd0;
    bus.i_thsh_mode = 1'b0;
    bus.i_thsh_vld  = 1'b0;
  endtask

  task automatic load(input logic [1:0] ch, input logic [12:0] val, input logic mode);
    bus.i_thsh_vld  = 1'b1;
    bus.i_thsh_ch   = ch;
    bus.i_thsh_val  = val;
    bus.i_thsh_mode = mode;
  endtask

  task automatic wr(input logic [12:0] a, input logic [15:0] d);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_addr = a;
    bus.i_wr_data = d;
  endtask

  // One cycle: check outputs against expectations, queue the data the
  // expected grant will return two cycles later, advance, then go idle.
  task automatic tick(input logic [3:0] xack, input logic [15:0] xd, input logic [3:0] xempty);
    ex_t n;
    @(negedge clk);
    chk("pop_ack", 32'(bus.o_pop_ack), 32'(xack));
    chk("empty", 32'(bus.o_empty), 32'(xempty));
    chk("thsh_done", 32'(bus.o_thsh_done), 32'(prev_tv));
    chk("vld", 32'(bus.o_vld), 32'(e1.v));
    if (e1.v) begin
      chk("front", 32'(bus.o_front), 32'(e1.d));
      chk("ch", 32'(bus.o_ch), 32'(e1.ch));
    end
    if (prev_rst) begin
      chk("front_after_rst", 32'(bus.o_front), 32'd0);
      chk("ch_after_rst", 32'(bus.o_ch), 32'd0);
    end
    n.v  = (xack != 4'h0);
    n.d  = xd;
    n.ch = oh2idx(xack);
    e1 = e0;
    e0 = n;
    if (rst) begin
      e0.v = 1'b0;
      e1.v = 1'b0;
    end
    prev_tv  = bus.i_thsh_vld & ~rst;
    prev_rst = rst;
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] xe;
    n_chk = 0;
    n_err = 0;
    e0 = '{v: 1'b0, d: 16'h0, ch: 2'd0};
    e1 = e0;
    prev_tv  = 1'b0;
    prev_rst = 1'b0;

    // Ch0 one-shot of 4 words, then pointer clears on loaded/unloaded channels.
    tbl[0]  = v(4'h0, 4'h0, 1'b0, 13'd0, 1'b1, 13'd0, 16'h00A0, 4'h0, 1'b0, 16'h0000, 4'hF, 1'b0);
    tbl[1]  = v(4'h0, 4'h0, 1'b0, 13'd0, 1'b1, 13'd1, 16'h00A1, 4'h0, 1'b0, 16'h0000, 4'hF, 1'b0);
    tbl[2]  = v(4'h0, 4'h0, 1'b0, 13'd0, 1'b1, 13'd2, 16'h00A2, 4'h0, 1'b0, 16'h0000, 4'hF, 1'b0);
    tbl[3]  = v(4'h0, 4'h0, 1'b0, 13'd0, 1'b1, 13'd3, 16'h00A3, 4'h0, 1'b0, 16'h0000, 4'hF, 1'b0);
    tbl[4]  = v(4'h1, 4'h0, 1'b1, 13'd3, 1'b0, 13'd0, 16'h0000, 4'h0, 1'b0, 16'h0000, 4'hF, 1'b0);
    tbl[5]  = v(4'h1, 4'h0, 1'b0, 13'd0, 1'b0, 13'd0, 16'h0000, 4'h1, 1'b0, 16'h0000, 4'hE, 1'b1);
    tbl[6]  = v(4'h1, 4'h0, 1'b0, 13'd0, 1'b0, 13'd0, 16'h0000, 4'h1, 1'b0, 16'h0000, 4'hE, 1'b0);
    tbl[7]  = v(4'h1, 4'h0, 1'b0, 13'd0, 1'b0, 13'd0, 16'h0000, 4'h1, 1'b1, 16'h00A0, 4'hE, 1'b0);
    tbl[8]  = v(4'h1, 4'h0, 1'b0, 13'd0, 1'b0, 13'd0, 16'h0000, 4'h1, 1'b1, 16'h00A1, 4'hE, 1'b0);
    tbl[9]  = v(4'h1, 4'h0, 1'b0, 13'd0, 1'b0, 13'd0, 16'h0000, 4'h0, 1'b1, 16'h00A2, 4'hF, 1'b0);
    tbl[10] = v(4'h1, 4'h0, 1'b0, 13'd0, 1'b0, 13'd0, 16'h0000, 4'h0, 1'b1, 16'h00A3, 4'hF, 1'b0);
    tbl[11] = v(4'h1, 4'h8, 1'b0, 13'd0, 1'b0, 13'd0, 16'h0000, 4'h0, 1'b0, 16'h0000, 4'hF, 1'b0);
    tbl[12] = v(4'h1, 4'h1, 1'b0, 13'd0, 1'b0, 13'd0, 16'h0000, 4'h0, 1'b0, 16'h0000, 4'hF, 1'b0);
    tbl[13] = v(4'h1, 4'h0, 1'b0, 13'd0, 1'b0, 13'd0, 16'h0000, 4'h1, 1'b0, 16'h0000, 4'hE, 1'b0);
    tbl[14] = v(4'h0, 4'h0, 1'b0, 13'd0, 1'b0, 13'd0, 16'h0000, 4'h0, 1'b0, 16'h0000, 4'hE, 1'b0);
    tbl[15] = v(4'h0, 4'h0, 1'b0, 13'd0, 1'b0, 13'd0, 16'h0000, 4'h0, 1'b1, 16'h00A0, 4'hE, 1'b0);
    tbl[16] = v(4'h0, 4'h0, 1'b0, 13'd0, 1'b0, 13'd0, 16'h0000, 4'h0, 1'b0, 16'h0000, 4'hE, 1'b0);

    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      bus.i_pop      = tbl[i].pop;
      bus.i_ptr_rst  = tbl[i].prst;
      bus.i_thsh_vld = tbl[i].tv;
      bus.i_thsh_val = tbl[i].tval;
      bus.i_wr_en    = tbl[i].we;
      bus.i_wr_addr  = tbl[i].wa;
      bus.i_wr_data  = tbl[i].wd;
      @(negedge clk);
      chk("tbl_ack", 32'(bus.o_pop_ack), 32'(tbl[i].ack));
      chk("tbl_vld", 32'(bus.o_vld), 32'(tbl[i].vld));
      chk("tbl_empty", 32'(bus.o_empty), 32'(tbl[i].empty));
      chk("tbl_done", 32'(bus.o_thsh_done), 32'(tbl[i].done));
      if (tbl[i].vld) begin
        chk("tbl_front", 32'(bus.o_front), 32'(tbl[i].front));
        chk("tbl_ch", 32'(bus.o_ch), 32'd0);
      end
      @(posedge clk);
      #1;
      idle();
    end

    // Reset, then four channels contending: strict rotation 0,1,2,3.
    rst = 1'b1;
    tick(4'h0, 16'h0, 4'hE);
    for (int k = 0; k < 8; k++) begin
      wr(13'(k), 16'(32'h100 + k));
      tick(4'h0, 16'h0, 4'hF);
    end
    for (int c = 0; c < 4; c++) begin
      load(2'(c), 13'd7, 1'b0);
      tick(4'h0, 16'h0, 4'(4'hF << c));
    end
    for (int k = 0; k < 32; k++) begin
      for (int c = 0; c < 4; c++) xe[c] = (k > 28 + c);
      bus.i_pop = 4'hF;
      tick(4'(1 << (k % 4)), 16'(32'h100 + k / 4), xe);
    end
    tick(4'h0, 16'h0, 4'hF);
    tick(4'h0, 16'h0, 4'hF);

    // Ch1 replay over 3 words, popped 7 times.
    load(2'd1, 13'd2, 1'b1);
    tick(4'h0, 16'h0, 4'hF);
    for (int k = 0; k < 7; k++) begin
      bus.i_pop = 4'h2;
      tick(4'h2, 16'(32'h100 + k % 3), 4'hD);
    end
    tick(4'h0, 16'h0, 4'hD);
    tick(4'h0, 16'h0, 4'hD);

    // Ch2: pointer clear collides with a pop at rptr=5.
    load(2'd2, 13'd7, 1'b0);
    tick(4'h0, 16'h0, 4'hD);
    for (int k = 0; k < 5; k++) begin
      bus.i_pop = 4'h4;
      tick(4'h4, 16'(32'h100 + k), 4'h9);
    end
    bus.i_pop     = 4'h4;
    bus.i_ptr_rst = 4'h4;
    tick(4'h0, 16'h0, 4'h9);
    bus.i_pop = 4'h4;
    tick(4'h4, 16'h0100, 4'h9);
    tick(4'h0, 16'h0, 4'h9);
    tick(4'h0, 16'h0, 4'h9);

    // Ch0: write and read of address 4 in the same cycle returns old data.
    load(2'd0, 13'd7, 1'b0);
    tick(4'h0, 16'h0, 4'h9);
    for (int k = 0; k < 4; k++) begin
      bus.i_pop = 4'h1;
      tick(4'h1, 16'(32'h100 + k), 4'h8);
    end
    bus.i_pop = 4'h1;
    wr(13'd4, 16'h0055);
    tick(4'h1, 16'h0104, 4'h8);
    bus.i_ptr_rst = 4'h1;
    tick(4'h0, 16'h0, 4'h8);
    for (int k = 0; k < 5; k++) begin
      bus.i_pop = 4'h1;
      tick(4'h1, (k == 4) ? 16'h0055 : 16'(32'h100 + k), 4'h8);
    end

    // Reset with two reads in flight and a threshold load in the same cycle.
    bus.i_pop = 4'h1;
    tick(4'h1, 16'h0105, 4'h8);
    bus.i_pop = 4'h1;
    tick(4'h1, 16'h0106, 4'h8);
    rst = 1'b1;
    load(2'd1, 13'd3, 1'b0);
    tick(4'h0, 16'h0, 4'h8);
    tick(4'h0, 16'h0, 4'hF);
    load(2'd0, 13'd1, 1'b0);
    tick(4'h0, 16'h0, 4'hF);
    bus.i_pop = 4'h1;
    tick(4'h1, 16'h0100, 4'hE);
    bus.i_pop = 4'h1;
    tick(4'h1, 16'h0101, 4'hE);
    bus.i_pop = 4'h1;
    tick(4'h0, 16'h0, 4'hF);
    tick(4'h0, 16'h0, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
`default_nettype wire
